tick_divider_bank: RTL and testbench

Parametrised bank of independent programmable tick generators. It is the successor to the single fixed-compare divider. Each channel divides `clk` by a runtime-programmable period and emits a one-cycle tick and, optionally, a square wave. Periods are reloaded glitch-free through a valid/ready config port, and a global sync input restarts all channels in phase. The bank sits next to the display-scan, debounce and baud logic that consume its ticks.

---
 rtl/tick_divider_bank.sv | 108 ++++++++++
 tb/tb_tick_divider_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_divider_bank.sv
// Bank of independent programmable tick generators with shadowed period reload
// through a valid/ready config port and a global in-phase restart.
module tick_divider_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_max,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] wave
);

    logic [WIDTH-1:0]    r_count     [CHANNELS];
    logic [WIDTH-1:0]    r_max       [CHANNELS];
    logic [WIDTH-1:0]    r_shadowMax [CHANNELS];
    logic [CHANNELS-1:0] r_mode;
    logic [CHANNELS-1:0] r_shadowMode;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_tick;
    logic [CHANNELS-1:0] r_wave;

    logic                w_cfgReady;
    logic [CHANNELS-1:0] w_accept;
    logic [CHANNELS-1:0] w_wrap;
    logic [CHANNELS-1:0] w_apply;

    // An index that matches no channel stays ready so the write is swallowed.
    always_comb begin
        w_cfgReady = 1'b1;
        w_accept   = '0;
        w_wrap     = '0;
        w_apply    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_cfgReady = ~r_pending[i];
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            w_accept[i] = cfg_valid && w_cfgReady && (cfg_ch == CH_W'(i));
            w_wrap[i]   = en[i] && (r_count[i] >= r_max[i]);
            w_apply[i]  = r_pending[i] && (sync || !en[i] || w_wrap[i]);
        end
    end

    // Later assignments win: shadow apply overrides the wave update, and a
    // new accept re-arms pending after the apply on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_count[i]     <= '0;
                r_max[i]       <= '0;
                r_shadowMax[i] <= '0;
            end
            r_mode       <= '0;
            r_shadowMode <= '0;
            r_pending    <= '0;
            r_tick       <= '0;
            r_wave       <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sync) begin
                    r_count[i] <= '0;
                    r_tick[i]  <= 1'b0;
                    r_wave[i]  <= 1'b0;
                end else if (!en[i]) begin
                    r_tick[i] <= 1'b0;
                end else if (w_wrap[i]) begin
                    r_count[i] <= '0;
                    r_tick[i]  <= 1'b1;
                    if (r_mode[i]) begin
                        r_wave[i] <= ~r_wave[i];
                    end
                end else begin
                    r_count[i] <= r_count[i] + WIDTH'(1);
                    r_tick[i]  <= 1'b0;
                end

                if (w_apply[i]) begin
                    r_max[i]     <= r_shadowMax[i];
                    r_mode[i]    <= r_shadowMode[i];
                    r_pending[i] <= 1'b0;
                    if (!r_shadowMode[i]) begin
                        r_wave[i] <= 1'b0;
                    end
                end

                if (w_accept[i]) begin
                    r_shadowMax[i]  <= cfg_max;
                    r_shadowMode[i] <= cfg_mode;
                    r_pending[i]    <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready = w_cfgReady;
    assign tick      = r_tick;
    assign wave      = r_wave;

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank: expected tick/wave vectors go into a
// scoreboard queue as each edge is stimulated and are popped after that edge.
module tb_tick_divider_bank;

    logic        clk;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_max;
    logic        cfg_mode;
    logic [3:0]  tick;
    logic [3:0]  wave;

    typedef struct {
        string      tag;
        logic [3:0] tick;
        logic [3:0] wave;
    } expEntry_t;

    expEntry_t sbQueue[$];
    int vectorCount = 0;
    int missCount   = 0;

    tick_divider_bank #(.CHANNELS(4), .WIDTH(32), .CH_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_max   (cfg_max),
        .cfg_mode  (cfg_mode),
        .tick      (tick),
        .wave      (wave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Push the expectation for the coming edge, clock it, then pop and compare.
    task automatic expectCycle(input string tag, input logic [3:0] expTick, input logic [3:0] expWave);
        expEntry_t e;
        e.tag  = tag;
        e.tick = expTick;
        e.wave = expWave;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        e = sbQueue.pop_front();
        checkOutput({e.tag, ".tick"}, 32'(tick), 32'(e.tick));
        checkOutput({e.tag, ".wave"}, 32'(wave), 32'(e.wave));
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        en        = '0;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_max   = '0;
        cfg_mode  = 1'b0;
        #2;
        checkOutput("rst.tick", 32'(tick), 32'd0);
        checkOutput("rst.wave", 32'(wave), 32'd0);
        checkOutput("rst.ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One accepted config write; leaves cfg_ch pointing at the written channel.
    task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] maxVal, input logic mode);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_max   = maxVal;
        cfg_mode  = mode;
        #1;
        checkOutput("cfg.readyBefore", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("cfg.readyAfter", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] tick_divider_bank directed run");

        // Default period: ch0 max=3 mode 0, others at reset max 0
        applyReset();
        applyStimulus(2'd0, 32'd3, 1'b0);
        expectCycle("t1.apply", 4'b0000, 4'b0000);
        checkOutput("t1.readyBack", 32'(cfg_ready), 32'd1);
        en = 4'b1111;
        for (int j = 1; j <= 12; j++) begin
            expectCycle("t1.run", {3'b111, (j % 4 == 0)}, 4'b0000);
        end

        // Square wave on ch1, max=4
        applyReset();
        applyStimulus(2'd1, 32'd4, 1'b1);
        expectCycle("t2.apply", 4'b0000, 4'b0000);
        en = 4'b0010;
        for (int j = 1; j <= 20; j++) begin
            expectCycle("t2.run", {2'b00, (j % 5 == 0), 1'b0}, {2'b00, ((j / 5) % 2 == 1), 1'b0});
        end

        // Glitch-free reload on ch2: max 9 -> 2 written at count 5
        applyReset();
        applyStimulus(2'd2, 32'd9, 1'b0);
        expectCycle("t3.apply", 4'b0000, 4'b0000);
        en = 4'b0100;
        for (int j = 1; j <= 22; j++) begin
            if (j == 6) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'd2;
                cfg_max   = 32'd2;
                cfg_mode  = 1'b0;
            end else if (j == 7) begin
                cfg_max = 32'd7;
            end else if (j == 9) begin
                cfg_valid = 1'b0;
            end
            expectCycle("t3.run", {1'b0, (j == 10) || (j > 10 && (j - 10) % 3 == 0), 2'b00}, 4'b0000);
            if (j == 6 || j == 8) begin
                checkOutput("t3.readyBusy", 32'(cfg_ready), 32'd0);
            end
            if (j == 10) begin
                checkOutput("t3.readyFree", 32'(cfg_ready), 32'd1);
            end
        end

        // Sync phase alignment: ch0 max=3, ch1 max=7
        applyReset();
        applyStimulus(2'd0, 32'd3, 1'b0);
        applyStimulus(2'd1, 32'd7, 1'b0);
        expectCycle("t4.apply", 4'b0000, 4'b0000);
        en = 4'b0011;
        for (int j = 1; j <= 5; j++) begin
            expectCycle("t4.pre", {3'b000, (j == 4)}, 4'b0000);
        end
        sync = 1'b1;
        expectCycle("t4.sync", 4'b0000, 4'b0000);
        sync = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            expectCycle("t4.post", {2'b00, (k == 8), (k % 4 == 0)}, 4'b0000);
        end

        // Disabled channel shrink: ch3 at count 50 of max 100, shrink to 10
        applyReset();
        applyStimulus(2'd3, 32'd100, 1'b0);
        expectCycle("t5.apply", 4'b0000, 4'b0000);
        en = 4'b1000;
        for (int j = 1; j <= 50; j++) begin
            expectCycle("t5.count", 4'b0000, 4'b0000);
        end
        en = 4'b0000;
        expectCycle("t5.hold", 4'b0000, 4'b0000);
        applyStimulus(2'd3, 32'd10, 1'b0);
        expectCycle("t5.apply2", 4'b0000, 4'b0000);
        checkOutput("t5.readyBack", 32'(cfg_ready), 32'd1);
        en = 4'b1000;
        for (int k = 1; k <= 23; k++) begin
            expectCycle("t5.run", {(k == 1) || (k > 1 && (k - 1) % 11 == 0), 3'b000}, 4'b0000);
        end

        // Max 0 square wave, mode change to 0 on a disabled channel, async reset
        applyReset();
        applyStimulus(2'd1, 32'd0, 1'b1);
        expectCycle("t6.apply", 4'b0000, 4'b0000);
        en = 4'b1111;
        for (int j = 1; j <= 3; j++) begin
            expectCycle("t6.run", 4'b1111, {2'b00, (j % 2 == 1), 1'b0});
        end
        en        = 4'b1101;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_max   = 32'd0;
        cfg_mode  = 1'b0;
        expectCycle("t6.accept", 4'b1101, 4'b0010);
        cfg_valid = 1'b0;
        expectCycle("t6.mode0", 4'b1101, 4'b0000);
        en = 4'b1111;
        expectCycle("t6.resume", 4'b1111, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6.asyncTick", 32'(tick), 32'd0);
        checkOutput("t6.asyncWave", 32'(wave), 32'd0);
        checkOutput("t6.asyncReady", 32'(cfg_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
